// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR conversion controller.
package sar_pkg;

    // Default number of converted bits.
    localparam int RESOLUTION_DEFAULT = 10;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_bit_pointer.sv
// sar_bit_pointer: one-hot pointer to the bit currently under trial.
// It starts at the MSB and moves one position toward the LSB per shift.
// last_o flags that the LSB is the bit being decided this cycle.
module sar_bit_pointer
    import sar_pkg::*;
#(
    parameter int WIDTH = RESOLUTION_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] ptr_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] ptr_q;

    // Reset and load both park the pointer on the MSB; shift walks it down.
    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            ptr_q <= TOP;
        end else if (shift_i) begin
            ptr_q <= ptr_q >> 1;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = ptr_q[0];

endmodule

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation ADC sequencer.
// Tracks the input while start is high, then binary-searches the DAC code
// one bit per cycle and pulses valid when the result is final.
// Optional feature: define SAR_DATA_HOLD_EN to give data_out its own register
// that only changes when a conversion completes; otherwise data_out mirrors
// dac_code directly.
module sar_controller
    import sar_pkg::*;
#(
    parameter int RESOLUTION = RESOLUTION_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cmp,
    output logic                  sample,
    output logic [RESOLUTION-1:0] dac_code,
    output logic [RESOLUTION-1:0] data_out,
    output logic                  valid,
    output logic                  overrun
);

    localparam logic [RESOLUTION-1:0] MSB_CODE = {1'b1, {(RESOLUTION-1){1'b0}}};

    sar_state_e            state_q;
    logic                  sample_q;
    logic [RESOLUTION-1:0] dac_q;
    logic [RESOLUTION-1:0] dac_d;
    logic                  valid_q;
    logic                  overrun_q;

    logic [RESOLUTION-1:0] ptr;
    logic                  ptr_last;
    logic                  ptr_load;
    logic                  ptr_shift;

    // Pointer reloads as sampling ends and advances once per conversion cycle.
    assign ptr_load  = (state_q == SAMPLE) && !start;
    assign ptr_shift = (state_q == CONVERT);

    sar_bit_pointer #(
        .WIDTH (RESOLUTION)
    ) u_ptr (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .load_i  (ptr_load),
        .shift_i (ptr_shift),
        .ptr_o   (ptr),
        .last_o  (ptr_last)
    );

    // Decision step: keep or drop the trial bit, then raise the next one down.
    // On the LSB the shifted pointer is zero, so no further bit is raised.
    always_comb begin
        dac_d = dac_q;
        if (!cmp) begin
            dac_d = dac_d & ~ptr;
        end
        dac_d = dac_d | (ptr >> 1);
    end

`ifdef SAR_DATA_HOLD_EN
    logic [RESOLUTION-1:0] data_q;

    // Result register: captures the final code as the FSM enters DONE so it
    // is presented together with valid and held until the next completion.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            data_q <= '0;
        end else if ((state_q == CONVERT) && ptr_last) begin
            data_q <= dac_d;
        end
    end

    assign data_out = data_q;
`else
    assign data_out = dac_q;
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            sample_q  <= 1'b0;
            dac_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                        dac_q    <= '0;
                    end
                end
                SAMPLE: begin
                    if (!start) begin
                        state_q  <= CONVERT;
                        sample_q <= 1'b0;
                        dac_q    <= MSB_CODE;
                    end
                end
                CONVERT: begin
                    // A start strobe here is flagged but never alters sequencing.
                    overrun_q <= start;
                    dac_q     <= dac_d;
                    if (ptr_last) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    overrun_q <= start;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sample  = sample_q;
    assign dac_code = dac_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: randomized self-checking bench for sar_controller.
// The reference derives every expected DAC trial code from the target result
// by binary-search arithmetic and the expected timing from frame cycle counts.
module tb_sar_controller;

    localparam int R    = 10;
    localparam int MAXC = (1 << R) - 1;

    logic         clk_in;
    logic         rst;
    logic         start;
    logic         cmp;
    logic         sample;
    logic [R-1:0] dac_code;
    logic [R-1:0] data_out;
    logic         valid;
    logic         overrun;

    int           n_tests;
    int           n_fail;
    int           cmp_mode;   // 0: cmp stuck 0, 1: cmp stuck 1, 2: comparator model
    logic [R-1:0] vin;
    int           last_res;   // most recent completed result (for held data_out)

    sar_controller #(
        .RESOLUTION (R)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .cmp      (cmp),
        .sample   (sample),
        .dac_code (dac_code),
        .data_out (data_out),
        .valid    (valid),
        .overrun  (overrun)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Trial code after k decisions of a binary search whose answer is res.
    function automatic int exp_trial(input int res, input int k);
        int mask;
        if (k >= R) return res;
        mask = MAXC ^ ((1 << (R - k)) - 1);
        return (res & mask) | (1 << (R - 1 - k));
    endfunction

    // Expected data_out given the expected DAC code at this point.
    function automatic int exp_data(input int dac);
`ifdef SAR_DATA_HOLD_EN
        return last_res;
`else
        return dac;
`endif
    endfunction

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
        case (cmp_mode)
            0:       cmp = 1'b0;
            1:       cmp = 1'b1;
            default: cmp = (vin >= dac_code);
        endcase
    endtask

    // One conversion frame. in_sample: FSM already in SAMPLE (skip the start
    // strobe). ovr_c: CONVERT cycle (1..R) in which start is pulsed, 0 = none.
    // done_start: raise start in the DONE cycle and keep it high afterwards.
    task automatic run_frame(input int mode, input int v, input bit in_sample,
                             input int ovr_c, input bit done_start);
        int res;
        int edac;
        cmp_mode = mode;
        vin      = v[R-1:0];
        res      = (mode == 0) ? 0 : (mode == 1) ? MAXC : (v & MAXC);
        if (!in_sample) begin
            start = 1'b1;
            step();
            check("smp_sample", int'(sample), 1);
            check("smp_dac", int'(dac_code), 0);
            check("smp_valid", int'(valid), 0);
            check("smp_data", int'(data_out), exp_data(0));
        end
        start = 1'b0;
        step();
        check("e0_sample", int'(sample), 0);
        check("e0_dac", int'(dac_code), exp_trial(res, 0));
        check("e0_valid", int'(valid), 0);
        for (int k = 1; k <= R; k++) begin
            start = (k == ovr_c);
            step();
            edac = exp_trial(res, k);
            if (k == R) last_res = res;
            check("cv_dac", int'(dac_code), edac);
            check("cv_data", int'(data_out), exp_data(edac));
            check("cv_valid", int'(valid), (k == R) ? 1 : 0);
            check("cv_overrun", int'(overrun), (k == ovr_c) ? 1 : 0);
        end
        start = done_start;
        step();
        check("post_valid", int'(valid), 0);
        check("post_overrun", int'(overrun), done_start ? 1 : 0);
        check("post_sample", int'(sample), 0);
        check("post_data", int'(data_out), exp_data(res));
        if (done_start) begin
            step();
            check("ds_sample", int'(sample), 1);
            check("ds_overrun", int'(overrun), 0);
            check("ds_dac", int'(dac_code), 0);
        end
    endtask

    // Frame aborted by a reset held during CONVERT cycle c.
    task automatic reset_frame(input int v, input int c);
        cmp_mode = 2;
        vin      = v[R-1:0];
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int k = 1; k < c; k++) step();
        rst = 1'b1;
        step();
        last_res = 0;
        check("rst_sample", int'(sample), 0);
        check("rst_dac", int'(dac_code), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("abort_valid", int'(valid), 0);
            check("abort_sample", int'(sample), 0);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_res = 0;
        cmp_mode = 0;
        vin      = '0;
        rst      = 1'b1;
        start    = 1'b0;
        cmp      = 1'b0;
        repeat (3) step();
        check("reset_sample", int'(sample), 0);
        check("reset_dac", int'(dac_code), 0);
        check("reset_data", int'(data_out), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        step();
        check("idle_sample", int'(sample), 0);

        // Stuck comparators, then the 0x2A5 comparator model.
        run_frame(1, MAXC, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        run_frame(2, 'h2A5, 0, 0, 0);

        // Start strobe in CONVERT cycle 4 must not disturb the result.
        run_frame(2, 'h155, 0, 4, 0);

        // Reset in CONVERT cycle 5, followed by a clean frame.
        reset_frame('h1C3, 5);
        run_frame(2, 'h1C3, 0, 0, 0);

        // Reset wins over start.
        rst   = 1'b1;
        start = 1'b1;
        step();
        check("prio_sample", int'(sample), 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("prio_idle", int'(sample), 0);

        // Back-to-back 13-cycle frames with random inputs.
        for (int f = 0; f < 20; f++) begin
            run_frame(2, int'($urandom_range(0, MAXC)), 0, 0, 0);
        end

        // Start raised in DONE re-enters SAMPLE on the following cycle.
        run_frame(2, int'($urandom_range(0, MAXC)), 0, 0, 1);
        run_frame(2, int'($urandom_range(0, MAXC)), 1, 0, 0);

        // Start held high keeps the FSM tracking.
        start = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            step();
            check("hold_sample", int'(sample), 1);
            check("hold_dac", int'(dac_code), 0);
            check("hold_valid", int'(valid), 0);
        end
        run_frame(2, int'($urandom_range(0, MAXC)), 1, 0, 0);

        // Random frames with random overrun placement.
        for (int f = 0; f < 12; f++) begin
            run_frame(2, int'($urandom_range(0, MAXC)), 0,
                      int'($urandom_range(0, R)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
